fft_feeder: RTL and testbench

FFT_FEEDER -- requirements
Module: fft_feeder

---
 rtl/fft_feeder_if.sv | 36 +++
 rtl/fft_feeder.sv | 135 +++++++++++++
 tb/tb_fft_feeder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_feeder_if.sv
// ---------------------------------------------------------------------------
// fft_feeder_if
// Purpose : bundles the operand handshake and the serial fft-stage outputs of
//           fft_feeder into one interface.
// Signals : start_valid / start_ready  operand bundle handshake
//           w1, w2, a1, a2, b1, b2     8-bit operands, sampled on accept
//           inp                        serial operand byte to the fft stage
//           readyin                    load/readout strobe to the fft stage
//           busy, done                 sequence status
// Modports: master drives operands and start_valid (the requester side);
//           slave is the fft_feeder side.
// ---------------------------------------------------------------------------
interface fft_feeder_if;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] w1;
    logic [7:0] w2;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] inp;
    logic       readyin;
    logic       busy;
    logic       done;

    modport master (
        output start_valid, w1, w2, a1, a2, b1, b2,
        input  start_ready, inp, readyin, busy, done
    );

    modport slave (
        input  start_valid, w1, w2, a1, a2, b1, b2,
        output start_ready, inp, readyin, busy, done
    );
endinterface

// File: rtl/fft_feeder.sv
// ---------------------------------------------------------------------------
// fft_feeder
// Purpose : accepts a bundle of six operands, then feeds them one at a time to
//           a downstream fft stage (kick strobe, six load strobes separated by
//           GAP idle cycles), issues NUM_READ readout strobes of READ_HIGH
//           cycles high / READ_HIGH cycles low, and pulses done.
// Ports   : clk  - single clock, rising edge
//           rst  - synchronous reset, active low
//           bus  - fft_feeder_if.slave (handshake, operands, inp, readyin,
//                  busy, done)
// ---------------------------------------------------------------------------
module fft_feeder #(
    parameter int GAP       = 2,
    parameter int NUM_READ  = 5,
    parameter int READ_HIGH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fft_feeder_if.slave  bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_KICK     = 3'd1;
    localparam logic [2:0] S_KICK_GAP = 3'd2;
    localparam logic [2:0] S_LOAD     = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_READ_HI  = 3'd5;
    localparam logic [2:0] S_READ_LO  = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    // Counters hold "remaining cycles minus one" so a state exits when 0.
    localparam logic [3:0] GAP_LD  = 4'(GAP - 1);
    localparam logic [3:0] HI_LD   = 4'(READ_HIGH - 1);
    localparam logic [3:0] NRD_LD  = 4'(NUM_READ - 1);
    localparam logic [2:0] LAST_OP = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      rd_q, rd_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      inp_q, inp_d;
    logic [5:0][7:0] op_q, op_d;
    logic [5:0][7:0] op_in;
    logic [2:0]      idx_nxt;

    // Element 0 is the first operand sent (w1).
    assign op_in   = {bus.b2, bus.b1, bus.a2, bus.a1, bus.w2, bus.w1};
    assign idx_nxt = idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        idx_d   = idx_q;
        inp_d   = inp_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_valid) begin
                    op_d    = op_in;
                    state_d = S_KICK;
                end
            end
            S_KICK: state_d = S_KICK_GAP;
            S_KICK_GAP: begin
                // inp changes together with the state entering LOAD so the
                // byte is already valid while the strobe is high.
                idx_d   = 3'd0;
                inp_d   = op_q[0];
                state_d = S_LOAD;
            end
            S_LOAD: begin
                cnt_d   = GAP_LD;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (idx_q == LAST_OP) begin
                    cnt_d   = HI_LD;
                    rd_d    = NRD_LD;
                    state_d = S_READ_HI;
                end else begin
                    idx_d   = idx_nxt;
                    inp_d   = op_q[idx_nxt];
                    state_d = S_LOAD;
                end
            end
            S_READ_HI: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d   = HI_LD;
                    state_d = S_READ_LO;
                end
            end
            S_READ_LO: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (rd_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    rd_d    = rd_q - 4'd1;
                    cnt_d   = HI_LD;
                    state_d = S_READ_HI;
                end
            end
            default: state_d = S_IDLE;  // S_DONE
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 4'd0;
            idx_q   <= 3'd0;
            inp_q   <= 8'h00;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            idx_q   <= idx_d;
            inp_q   <= inp_d;
            op_q    <= op_d;
        end
    end

    assign bus.start_ready = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.readyin     = (state_q == S_KICK) || (state_q == S_LOAD) ||
                             (state_q == S_READ_HI);
    assign bus.inp         = inp_q;
endmodule

// File: tb/tb_fft_feeder.sv
// ---------------------------------------------------------------------------
// tb_fft_feeder
// Two feeders share one clock and reset: u_a with default parameters and
// u_b with GAP=1, NUM_READ=1, READ_HIGH=1. Each run pushes its expected
// per-cycle trace (built from the timeline formulas) into a queue; the
// queue is popped and compared once per cycle at the falling edge.
// ---------------------------------------------------------------------------
module tb_fft_feeder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_feeder_if ifa ();
    fft_feeder_if ifb ();

    fft_feeder u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    fft_feeder #(.GAP(1), .NUM_READ(1), .READ_HIGH(1)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        logic       ry;
        logic       dn;
        logic       bz;
        logic       sr;
        logic [7:0] inp;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic set_in(input int sel, input logic v, input logic [5:0][7:0] o);
        if (sel == 0) begin
            ifa.start_valid = v;
            ifa.w1 = o[0]; ifa.w2 = o[1]; ifa.a1 = o[2];
            ifa.a2 = o[3]; ifa.b1 = o[4]; ifa.b2 = o[5];
        end else begin
            ifb.start_valid = v;
            ifb.w1 = o[0]; ifb.w2 = o[1]; ifb.a1 = o[2];
            ifb.a2 = o[3]; ifb.b1 = o[4]; ifb.b2 = o[5];
        end
    endtask

    task automatic get(input int sel, output exp_t s);
        if (sel == 0) begin
            s.ry = ifa.readyin; s.dn = ifa.done; s.bz = ifa.busy;
            s.sr = ifa.start_ready; s.inp = ifa.inp;
        end else begin
            s.ry = ifb.readyin; s.dn = ifb.done; s.bz = ifb.busy;
            s.sr = ifb.start_ready; s.inp = ifb.inp;
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        exp_t s;
        get(sel, s);
        chk({tag, "_ry"}, 32'(s.ry), 32'd0);
        chk({tag, "_dn"}, 32'(s.dn), 32'd0);
        chk({tag, "_bz"}, 32'(s.bz), 32'd0);
        chk({tag, "_sr"}, 32'(s.sr), 32'd1);
    endtask

    // Expected trace for cycles 1 .. done+1 after the accept cycle (cycle 0).
    task automatic push_run(input int g, input int nr, input int rh,
                            input logic [5:0][7:0] ops, input logic [7:0] prev);
        int r0;
        int t;
        logic [7:0] cur;
        exp_t e;
        bit   ld;
        r0  = 3 + 6 * (1 + g);
        t   = r0 + 2 * nr * rh;
        cur = prev;
        for (int c = 1; c <= t + 1; c++) begin
            ld = (c >= 3) && (c < r0) && (((c - 3) % (1 + g)) == 0);
            if (ld) cur = ops[(c - 3) / (1 + g)];
            e.ry  = (c == 1) || ld || ((c >= r0) && (c < t) && (((c - r0) % (2 * rh)) < rh));
            e.inp = cur;
            e.dn  = (c == t);
            e.bz  = (c <= t);
            e.sr  = (c > t);
            exp_q.push_back(e);
        end
    endtask

    // Called at a falling edge. hold keeps start_valid high and presents alt
    // operands during the run; otherwise start_valid drops after accept.
    task automatic run(input int sel, input logic [5:0][7:0] ops, input bit hold,
                       input logic [5:0][7:0] alt, input logic [7:0] prev);
        exp_t s;
        exp_t e;
        int   cyc;
        int   bad0;
        if (sel == 0) push_run(2, 5, 2, ops, prev);
        else          push_run(1, 1, 1, ops, prev);
        bad0 = n_bad;
        set_in(sel, 1'b1, ops);
        get(sel, s);
        chk("accept_ready", 32'(s.sr), 32'd1);
        @(posedge clk);
        #1;
        set_in(sel, hold, alt);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            e = exp_q.pop_front();
            get(sel, s);
            chk($sformatf("c%0d_readyin", cyc), 32'(s.ry),  32'(e.ry));
            chk($sformatf("c%0d_done", cyc),    32'(s.dn),  32'(e.dn));
            chk($sformatf("c%0d_busy", cyc),    32'(s.bz),  32'(e.bz));
            chk($sformatf("c%0d_start_ready", cyc), 32'(s.sr), 32'(e.sr));
            chk($sformatf("c%0d_inp", cyc),     32'(s.inp), 32'(e.inp));
        end
        $display("run dut=%0d ops=%h hold=%0d cycles=%0d errors=%0d",
                 sel, ops, hold, cyc, n_bad - bad0);
    endtask

    logic [5:0][7:0] op_p;
    logic [5:0][7:0] op_q2;
    logic [5:0][7:0] op_r;
    logic [5:0][7:0] zero_ops;

    initial begin
        exp_t s;
        op_p     = {8'h06, 8'h05, 8'h03, 8'h02, 8'hC0, 8'h60};
        op_q2    = {8'hF6, 8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        op_r     = {8'h3C, 8'h2B, 8'h1A, 8'h99, 8'h88, 8'h77};
        zero_ops = '0;
        rst = 1'b0;
        set_in(0, 1'b0, zero_ops);
        set_in(1, 1'b0, zero_ops);
        repeat (3) @(negedge clk);
        check_idle(0, "rst_a");
        check_idle(1, "rst_b");
        get(0, s);
        chk("rst_a_inp", 32'(s.inp), 32'h00);
        rst = 1'b1;

        // Quiet period: nothing happens without start_valid.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle(0, $sformatf("quiet%0d_a", i));
            check_idle(1, $sformatf("quiet%0d_b", i));
        end

        // Default timeline, then start_valid held through a run with changed
        // operands, then the back-to-back re-accept of those operands.
        run(0, op_p, 1'b0, op_p, 8'h00);
        run(0, op_p, 1'b1, op_q2, op_p[5]);
        run(0, op_q2, 1'b0, op_q2, op_p[5]);

        // Minimum-parameter instance.
        run(1, op_r, 1'b0, op_r, 8'h00);

        // Reset in the GAP after the a1 load, with start_valid asserted.
        set_in(0, 1'b1, op_p);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, op_p);
        repeat (9) @(negedge clk);
        get(0, s);
        chk("c9_load_a1_ry", 32'(s.ry), 32'd1);
        chk("c9_load_a1_inp", 32'(s.inp), 32'(op_p[2]));
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 1'b1, op_q2);
        @(negedge clk);
        check_idle(0, "after_rst");
        get(0, s);
        chk("after_rst_inp", 32'(s.inp), 32'h00);
        rst = 1'b1;
        set_in(0, 1'b0, op_q2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_idle(0, $sformatf("post_rst%0d", i));
        end

        // A clean run after the reset restores normal operation.
        run(0, op_r, 1'b0, op_r, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
